// File: rtl/packet_tx_egress.sv
// packet_tx_egress: store-and-forward egress buffer that holds each frame
// until its permit/deny verdict, then forwards it on txd or discards it.
//
// Ports:
//   clk, rst                        clock, async active-low reset
//   i_data_*, o_data_tready         AXI-Stream frame input from the parser
//   i_verdict_valid, i_verdict_deny one-cycle per-frame verdict strobe
//   o_txd_*, i_txd_tready           AXI-Stream output to the MAC
//   o_drop_count                    saturating count of discarded frames
//   o_overflow                      sticky: a frame was truncated by full buffer
module packet_tx_egress #(
    parameter int C_TDATA_WIDTH = 32,
    parameter int FIFO_AW       = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_data_tvalid,
    input  logic [C_TDATA_WIDTH-1:0] i_data_tdata,
    input  logic                     i_data_tlast,
    output logic                     o_data_tready,
    input  logic                     i_verdict_valid,
    input  logic                     i_verdict_deny,
    output logic                     o_txd_tvalid,
    output logic [C_TDATA_WIDTH-1:0] o_txd_tdata,
    output logic                     o_txd_tlast,
    input  logic                     i_txd_tready,
    output logic [15:0]              o_drop_count,
    output logic                     o_overflow
);

    localparam int DW    = C_TDATA_WIDTH + 1;
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        RECV,
        DROP,
        WAIT_VERDICT
    } wr_state_t;

    wr_state_t state;

    logic [DW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] wr_ptr_nxt;
    logic [FIFO_AW-1:0] commit_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] fetch_ptr;
    logic               ovf_flag;
    logic               full;
    logic               accept;
    logic               mem_we;

    logic [DW-1:0]      ram_q;
    logic               ram_q_valid;
    logic               load_out;
    logic               rd_issue;
    logic               tx_hs;

    assign wr_ptr_nxt = wr_ptr + 1'b1;
    // rd_ptr only moves on a txd handshake, so words still sitting in the
    // read pipeline keep their slot reserved.
    assign full   = (wr_ptr_nxt == rd_ptr);
    assign accept = i_data_tvalid & o_data_tready;
    assign mem_we = (state == RECV) & accept & ~full;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= {i_data_tlast, i_data_tdata};
        end
    end

    // Write side: receive, drop on overflow, then hold for the verdict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= RECV;
            o_data_tready <= 1'b0;
            wr_ptr        <= '0;
            commit_ptr    <= '0;
            ovf_flag      <= 1'b0;
            o_drop_count  <= '0;
            o_overflow    <= 1'b0;
        end else begin
            unique case (state)
                RECV: begin
                    o_data_tready <= 1'b1;
                    if (accept) begin
                        if (full) begin
                            o_overflow <= 1'b1;
                            ovf_flag   <= 1'b1;
                            if (i_data_tlast) begin
                                state         <= WAIT_VERDICT;
                                o_data_tready <= 1'b0;
                            end else begin
                                state <= DROP;
                            end
                        end else begin
                            wr_ptr <= wr_ptr_nxt;
                            if (i_data_tlast) begin
                                state         <= WAIT_VERDICT;
                                o_data_tready <= 1'b0;
                            end
                        end
                    end
                end
                DROP: begin
                    o_data_tready <= 1'b1;
                    if (accept && i_data_tlast) begin
                        state         <= WAIT_VERDICT;
                        o_data_tready <= 1'b0;
                    end
                end
                WAIT_VERDICT: begin
                    o_data_tready <= 1'b0;
                    if (i_verdict_valid) begin
                        if (!i_verdict_deny && !ovf_flag) begin
                            commit_ptr <= wr_ptr;
                        end else begin
                            wr_ptr <= commit_ptr;
                            if (o_drop_count != 16'hFFFF) begin
                                o_drop_count <= o_drop_count + 16'd1;
                            end
                        end
                        ovf_flag      <= 1'b0;
                        state         <= RECV;
                        o_data_tready <= 1'b1;
                    end
                end
                default: begin
                    state         <= RECV;
                    o_data_tready <= 1'b0;
                end
            endcase
        end
    end

    // Read side: synchronous RAM read into ram_q, then the registered
    // output stage. fetch_ptr runs ahead of rd_ptr by the words in flight.
    assign tx_hs    = o_txd_tvalid & i_txd_tready;
    assign load_out = ram_q_valid & (~o_txd_tvalid | i_txd_tready);
    assign rd_issue = (fetch_ptr != commit_ptr) & (~ram_q_valid | load_out);

    always_ff @(posedge clk) begin
        if (rd_issue) begin
            ram_q <= mem[fetch_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_ptr    <= '0;
            rd_ptr       <= '0;
            ram_q_valid  <= 1'b0;
            o_txd_tvalid <= 1'b0;
            o_txd_tdata  <= '0;
            o_txd_tlast  <= 1'b0;
        end else begin
            if (rd_issue) begin
                fetch_ptr <= fetch_ptr + 1'b1;
            end
            ram_q_valid <= rd_issue | (ram_q_valid & ~load_out);
            if (load_out) begin
                o_txd_tvalid <= 1'b1;
                o_txd_tlast  <= ram_q[DW-1];
                o_txd_tdata  <= ram_q[C_TDATA_WIDTH-1:0];
            end else if (tx_hs) begin
                o_txd_tvalid <= 1'b0;
            end
            if (tx_hs) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule
